// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer on refclk: pulses PLL reset, waits for lock, qualifies stability, raises clk_ready.
// Define PLL_LOCK_STATUS_EN to add the lock_loss_cnt port and its saturating lock-loss counter.
module pll_lock_sequencer #(
  parameter int RST_CYCLES   = 50,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int LOCK_STABLE  = 1024,
  parameter int MAX_RETRIES  = 3,
  parameter int CNT_W        = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic [1:0] retry_cnt,
  output logic [2:0] state_o
`ifdef PLL_LOCK_STATUS_EN
  ,
  output logic [7:0] lock_loss_cnt
`endif
);

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    READY     = 3'd3,
    FAULT     = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
  localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sync1;
  logic             locked_s;
  logic [1:0]       retry_next;

  assign state_o    = state;
  assign retry_next = retry_cnt + 2'd1;

  // pll_locked comes from the PLL's own domain, so it is double-flopped before use
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      sync1    <= pll_locked;
      locked_s <= sync1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else if (restart) begin
      state     <= RESET;
      cnt       <= '0;
      pll_rst   <= 1'b1;
      clk_ready <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 2'd0;
    end else begin
      case (state)
        RESET: begin
          clk_ready <= 1'b0;
          if (cnt == RST_LAST) begin
            state   <= WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end else begin
            pll_rst <= 1'b1;
            cnt     <= cnt + CNT_ONE;
          end
        end
        WAIT_LOCK: begin
          // a lock seen on the timeout cycle still counts as a successful lock
          if (locked_s) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_cnt != RETRY_MAX) retry_cnt <= retry_next;
            if (retry_next == RETRY_MAX) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state <= RESET;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= READY;
            cnt       <= '0;
            clk_ready <= 1'b1;
            retry_cnt <= 2'd0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        READY: begin
          if (!locked_s) begin
            state     <= RESET;
            cnt       <= '0;
            clk_ready <= 1'b0;
            pll_rst   <= 1'b1;
          end
        end
        FAULT: begin
          pll_rst   <= 1'b1;
          clk_ready <= 1'b0;
          fault     <= 1'b1;
        end
        default: begin
          state     <= RESET;
          cnt       <= '0;
          pll_rst   <= 1'b1;
          clk_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef PLL_LOCK_STATUS_EN
  // Counts only lock losses out of READY; restart clears it along with the retry history
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      lock_loss_cnt <= 8'd0;
    end else if (restart) begin
      lock_loss_cnt <= 8'd0;
    end else if (state == READY && !locked_s && lock_loss_cnt != 8'hFF) begin
      lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end
`else
  // No lock-loss statistics in this build.
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer: the stimulus pushes expected state-change events,
// and a negedge monitor pops and checks each one, including the dwell time in the previous state.
module tb_pll_lock_sequencer;

  localparam int RST_CYCLES   = 50;
  localparam int LOCK_TIMEOUT = 100;
  localparam int LOCK_STABLE  = 16;
  localparam int MAX_RETRIES  = 3;
  localparam int BUDGET       = 1000;

  typedef struct {
    logic [2:0] state;
    logic       pll_rst;
    logic       clk_ready;
    logic       fault;
    logic [1:0] retry;
    int         dt;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;

  logic       refclk = 1'b0;
  logic       rst_n;
  logic       restart;
  logic       pll_locked;
  logic       pll_rst;
  logic       clk_ready;
  logic       fault;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;
`ifdef PLL_LOCK_STATUS_EN
  logic [7:0] lock_loss_cnt;
`endif

  pll_lock_sequencer #(
    .RST_CYCLES(RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE(LOCK_STABLE),
    .MAX_RETRIES(MAX_RETRIES),
    .CNT_W(16)
  ) dut (
    .refclk(refclk),
    .rst_n(rst_n),
    .restart(restart),
    .pll_locked(pll_locked),
    .pll_rst(pll_rst),
    .clk_ready(clk_ready),
    .fault(fault),
    .retry_cnt(retry_cnt),
    .state_o(state_o)
`ifdef PLL_LOCK_STATUS_EN
    ,
    .lock_loss_cnt(lock_loss_cnt)
`endif
  );

  always #5 refclk = ~refclk;
  always @(posedge refclk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic rst_v, input logic restart_v, input logic locked_v);
    rst_n      = rst_v;
    restart    = restart_v;
    pll_locked = locked_v;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge refclk);
      #1;
    end
  endtask

  // Expected outputs per state are fixed: PLL held in reset in RESET/FAULT, ready only in READY
  task automatic expectEvent(input logic [2:0] s, input logic [1:0] r, input int dt);
    ev_t e;
    e.state     = s;
    e.pll_rst   = (s == 3'd0) || (s == 3'd4);
    e.clk_ready = (s == 3'd3);
    e.fault     = (s == 3'd4);
    e.retry     = r;
    e.dt        = dt;
    sb.push_back(e);
  endtask

  task automatic waitState(input logic [2:0] s);
    int n = 0;
    while (state_o !== s && n < BUDGET) begin
      @(posedge refclk);
      #1;
      n++;
    end
    if (state_o !== s) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_state: got state %0d, expected %0d within %0d cycles", state_o, s, BUDGET);
    end
  endtask

  // Monitor: every state change is a DUT event that must match the head of the scoreboard
  initial begin
    logic [2:0] prev;
    int         last;
    ev_t        e;
    prev = 3'd0;
    last = 0;
    forever begin
      @(negedge refclk);
      if (state_o !== prev) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_event: got state %0d, expected none (cycle %0d)", state_o, cyc);
        end else begin
          e = sb.pop_front();
          checkOutput("state", int'(state_o), int'(e.state));
          checkOutput("outputs{rst,ready,fault,retry}", int'({pll_rst, clk_ready, fault, retry_cnt}),
                      int'({e.pll_rst, e.clk_ready, e.fault, e.retry}));
          if (e.dt >= 0) checkOutput("dwell_cycles", cyc - last, e.dt);
        end
        last = cyc;
        prev = state_o;
      end
      checkOutput("ready_exclusive", int'(clk_ready && (pll_rst || state_o != 3'd3)), 0);
      if (!rst_n) begin
        last = cyc + 1;
        prev = state_o;
      end
    end
  end

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    tick(3);

    // T1: normal bring-up, lock 10 cycles after pll_rst falls
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd2, 2'd0, 13);
    expectEvent(3'd3, 2'd0, LOCK_STABLE);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd1);
    tick(10);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd3);

    // T4: lock loss in READY forces a full PLL reset, then re-lock
    expectEvent(3'd0, 2'd0, 8);
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd2, 2'd0, 3);
    expectEvent(3'd3, 2'd0, LOCK_STABLE);
    tick(5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd0);
    waitState(3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd3);
`ifdef PLL_LOCK_STATUS_EN
    checkOutput("lock_loss_cnt", int'(lock_loss_cnt), 1);
`endif

    // T3: restart from READY, then a one-cycle lock glitch at stable count 8
    expectEvent(3'd0, 2'd0, 1);
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd2, 2'd0, 3);
    expectEvent(3'd1, 2'd0, 9);
    expectEvent(3'd2, 2'd0, 1);
    expectEvent(3'd3, 2'd0, LOCK_STABLE);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd2);
    tick(6);
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd3);

    // T2: lock lost and never returns -> three timeouts -> FAULT, then restart clears it
    expectEvent(3'd0, 2'd0, 3);
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd0, 2'd1, LOCK_TIMEOUT);
    expectEvent(3'd1, 2'd1, RST_CYCLES);
    expectEvent(3'd0, 2'd2, LOCK_TIMEOUT);
    expectEvent(3'd1, 2'd2, RST_CYCLES);
    expectEvent(3'd4, 2'd3, LOCK_TIMEOUT);
    expectEvent(3'd0, 2'd0, 21);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd4);
    tick(20);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // T6: restart on the same edge as a WAIT_LOCK timeout leaves retry_cnt at 0
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd0, 2'd0, LOCK_TIMEOUT);
    waitState(3'd1);
    tick(LOCK_TIMEOUT - 1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    tick(1);
    applyStimulus(1'b1, 1'b0, 1'b0);

    // T5: async reset in the middle of STABLE, then a clean restart of the sequence
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    expectEvent(3'd2, 2'd0, 3);
    expectEvent(3'd0, 2'd0, -1);
    expectEvent(3'd1, 2'd0, RST_CYCLES);
    waitState(3'd1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    waitState(3'd2);
    tick(8);
    applyStimulus(1'b0, 1'b0, 1'b0);
    tick(3);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(3'd1);
    tick(5);

    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
